// File: rtl/keypad_number_entry_if.sv
// Key-event, display and result handshake bundle for keypad_number_entry.
// The slave modport is the controller's view of the bundle.
interface keypad_number_entry_if #(
  parameter int MAX_DIGITS = 4,
  parameter int WIDTH      = 16
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    result_ack;
  logic [4*MAX_DIGITS-1:0] digits;
  logic [CW-1:0]           digit_count;
  logic                    negative;
  logic                    busy;
  logic [WIDTH-1:0]        result;
  logic                    result_valid;
  logic                    overflow;
  logic                    key_reject;

  modport master (
    output key_valid, key_code, result_ack,
    input  digits, digit_count, negative, busy, result, result_valid, overflow, key_reject
  );

  modport slave (
    input  key_valid, key_code, result_ack,
    output digits, digit_count, negative, busy, result, result_valid, overflow, key_reject
  );
endinterface

// File: rtl/keypad_number_entry.sv
// Keypad number-entry controller: builds a signed BCD operand from key events,
// converts it to saturated two's complement and holds it under valid/ack.
//
// state     | meaning
// S_EMPTY   | no digits stored; sign, enter and clear still act
// S_ENTRY   | 1..MAX_DIGITS digits stored
// S_CONVERT | BCD to binary, one digit per cycle, most significant first
// S_HOLD    | result_valid high until result_ack
module keypad_number_entry #(
  parameter int MAX_DIGITS     = 4,
  parameter int WIDTH          = 16,
  parameter bit ALLOW_NEGATIVE = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  keypad_number_entry_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int DW = 4 * MAX_DIGITS;
  localparam int AW = $clog2(10 ** MAX_DIGITS);
  localparam int XW = ((AW > WIDTH) ? AW : WIDTH) + 1;
  localparam logic [XW-1:0] NEG_LIM = XW'(1) << (WIDTH - 1);
  localparam logic [XW-1:0] POS_LIM = NEG_LIM - XW'(1);

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_CONVERT, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             rej_q, rej_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [3:0]       digit_sel;
  logic [XW-1:0]    acc_next;

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    count_d   = count_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    rej_d     = 1'b0;
    digit_sel = 4'(digits_q >> {idx_q, 2'b00});
    acc_next  = XW'(acc_q) * XW'(10) + XW'(digit_sel);

    case (state_q)
      S_EMPTY, S_ENTRY: begin
        if (bus.key_valid) begin
          if (bus.key_code <= 4'd9) begin
            // a leading zero is silently dropped, not rejected
            if (!(count_q == '0 && bus.key_code == 4'd0)) begin
              if (count_q == CW'(MAX_DIGITS)) begin
                rej_d = 1'b1;
              end else begin
                digits_d = (digits_q << 4) | DW'(bus.key_code);
                count_d  = count_q + CW'(1);
                state_d  = S_ENTRY;
              end
            end
          end else begin
            case (bus.key_code)
              4'hA: begin
                if (count_q == '0) begin
                  rej_d = 1'b1;
                end else begin
                  digits_d = digits_q >> 4;
                  count_d  = count_q - CW'(1);
                  if (count_q == CW'(1)) state_d = S_EMPTY;
                end
              end
              4'hB: begin
                digits_d = '0;
                count_d  = '0;
                neg_d    = 1'b0;
                state_d  = S_EMPTY;
              end
              4'hC: begin
                if (ALLOW_NEGATIVE) neg_d = ~neg_q;
                else                rej_d = 1'b1;
              end
              4'hD: begin
                acc_d   = '0;
                idx_d   = CW'(MAX_DIGITS - 1);
                state_d = S_CONVERT;
              end
              default: rej_d = 1'b1;
            endcase
          end
        end
      end
      S_CONVERT: begin
        rej_d = bus.key_valid;
        acc_d = AW'(acc_next);
        if (idx_q == '0) begin
          state_d = S_HOLD;
          if (!neg_q && acc_next > POS_LIM) begin
            result_d = WIDTH'(POS_LIM);
            ovf_d    = 1'b1;
          end else if (neg_q && acc_next > NEG_LIM) begin
            result_d = WIDTH'(NEG_LIM);
            ovf_d    = 1'b1;
          end else begin
            result_d = neg_q ? WIDTH'(-acc_next) : WIDTH'(acc_next);
            ovf_d    = 1'b0;
          end
        end else begin
          idx_d = idx_q - CW'(1);
        end
      end
      S_HOLD: begin
        rej_d = bus.key_valid;
        if (bus.result_ack) begin
          digits_d = '0;
          count_d  = '0;
          neg_d    = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    busy_d  = (state_d == S_CONVERT);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      digits_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.digits       = digits_q;
  assign bus.digit_count  = count_q;
  assign bus.negative     = neg_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.key_reject   = rej_q;
endmodule

// File: tb/tb_keypad_number_entry.sv
// Bench for keypad_number_entry: a 16-bit and an 8-bit instance see identical
// key streams and are checked against a digit-queue reference model.
module tb_keypad_number_entry;
  localparam int MD = 4;
  localparam int M_IDLE = 0, M_TYPING = 1, M_CONV = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_number_entry_if #(.MAX_DIGITS(MD), .WIDTH(16)) bus ();
  keypad_number_entry_if #(.MAX_DIGITS(MD), .WIDTH(8))  bus8 ();

  keypad_number_entry #(.MAX_DIGITS(MD), .WIDTH(16), .ALLOW_NEGATIVE(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  keypad_number_entry #(.MAX_DIGITS(MD), .WIDTH(8), .ALLOW_NEGATIVE(1'b1)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8));

  int n_vec = 0;
  int n_bad = 0;

  // reference model: digits kept most significant first
  int     mq[$];
  bit     m_neg, m_rej, m_ovf16, m_ovf8;
  int     m_state, m_left;
  longint m_res16, m_res8;

  function automatic logic [15:0] m_bcd();
    logic [15:0] r = '0;
    foreach (mq[i]) r = (r << 4) | 16'(mq[i]);
    return r;
  endfunction

  task automatic saturate(input longint mag, input bit neg, input int w,
                          output longint res, output bit ovf);
    longint lim = longint'(1) << (w - 1);
    if (!neg && mag > lim - 1) begin res = lim - 1; ovf = 1'b1; end
    else if (neg && mag > lim) begin res = -lim; ovf = 1'b1; end
    else begin res = neg ? -mag : mag; ovf = 1'b0; end
  endtask

  task automatic model_edge(input bit kv, input logic [3:0] kc, input bit ack, input bit rst);
    longint mag;
    m_rej = 1'b0;
    if (rst) begin
      mq.delete(); m_neg = 0; m_state = M_IDLE; m_left = 0;
      m_res16 = 0; m_res8 = 0; m_ovf16 = 0; m_ovf8 = 0;
    end else begin
      case (m_state)
        M_IDLE, M_TYPING: if (kv) begin
          if (kc <= 4'd9) begin
            if (!(mq.size() == 0 && kc == 4'd0)) begin
              if (mq.size() == MD) m_rej = 1'b1;
              else mq.push_back(int'(kc));
            end
          end else if (kc == 4'hA) begin
            if (mq.size() == 0) m_rej = 1'b1;
            else void'(mq.pop_back());
          end else if (kc == 4'hB) begin
            mq.delete(); m_neg = 0;
          end else if (kc == 4'hC) begin
            m_neg = !m_neg;
          end else if (kc == 4'hD) begin
            m_state = M_CONV; m_left = MD;
          end else begin
            m_rej = 1'b1;
          end
          if (m_state != M_CONV) m_state = (mq.size() == 0) ? M_IDLE : M_TYPING;
        end
        M_CONV: begin
          m_rej = kv;
          m_left--;
          if (m_left == 0) begin
            mag = 0;
            foreach (mq[i]) mag = mag * 10 + mq[i];
            saturate(mag, m_neg, 16, m_res16, m_ovf16);
            saturate(mag, m_neg, 8, m_res8, m_ovf8);
            m_state = M_HOLD;
          end
        end
        default: begin
          m_rej = kv;
          if (ack) begin
            mq.delete(); m_neg = 0; m_ovf16 = 0; m_ovf8 = 0; m_state = M_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit kv, input logic [3:0] kc, input bit ack, input bit rst);
    reset = rst;
    bus.key_valid = kv;  bus.key_code = kc;  bus.result_ack = ack;
    bus8.key_valid = kv; bus8.key_code = kc; bus8.result_ack = ack;
    @(posedge clk);
    model_edge(kv, kc, ack, rst);
    #1;
    reset = 1'b0;
    bus.key_valid = 1'b0;  bus.result_ack = 1'b0;
    bus8.key_valid = 1'b0; bus8.result_ack = 1'b0;
  endtask

  task automatic key(input logic [3:0] kc);
    step(1'b1, kc, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    n_vec++;
    if ({bus.digits, bus.digit_count, bus.negative, bus.busy, bus.result,
         bus.result_valid, bus.overflow, bus.key_reject} !== '0) begin
      n_bad++;
      $display("FAIL reset16 actual digits=%h cnt=%0d neg=%b busy=%b res=%h v=%b ovf=%b rej=%b required all 0",
               bus.digits, bus.digit_count, bus.negative, bus.busy, bus.result,
               bus.result_valid, bus.overflow, bus.key_reject);
    end
    n_vec++;
    if ({bus8.digits, bus8.digit_count, bus8.negative, bus8.busy, bus8.result,
         bus8.result_valid, bus8.overflow, bus8.key_reject} !== '0) begin
      n_bad++;
      $display("FAIL reset8 actual res=%h v=%b busy=%b required all 0",
               bus8.result, bus8.result_valid, bus8.busy);
    end
  endtask

  task automatic test_entry_convert();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    key(4'd1); key(4'd2); key(4'd3);
    n_vec++;
    if (bus.digits !== 16'h0123 || bus.digit_count !== 3'd3) begin
      n_bad++;
      $display("FAIL p1_entry actual digits=%h cnt=%0d required 0123/3", bus.digits, bus.digit_count);
    end
    key(4'hD);
    for (int i = 1; i <= MD; i++) begin
      n_vec++;
      if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL p1_busy t+%0d actual busy=%b valid=%b required 1/0", i, bus.busy, bus.result_valid);
      end
      if (i < MD) idle(1);
    end
    idle(1);
    n_vec++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 16'd123 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL p1_result actual v=%b busy=%b res=%0d ovf=%b required 1/0/123/0",
               bus.result_valid, bus.busy, $signed(bus.result), bus.overflow);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0);
    n_vec++;
    if (bus.result_valid !== 1'b0 || bus.digits !== 16'h0 || bus.digit_count !== 3'd0) begin
      n_bad++;
      $display("FAIL p1_ack actual v=%b digits=%h cnt=%0d required 0/0000/0",
               bus.result_valid, bus.digits, bus.digit_count);
    end
  endtask

  task automatic test_digit_limit_sign();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) key(4'd9);
    n_vec++;
    if (bus.key_reject !== 1'b1 || bus.digit_count !== 3'd4 || bus.digits !== 16'h9999) begin
      n_bad++;
      $display("FAIL p2_limit actual rej=%b cnt=%0d digits=%h required 1/4/9999",
               bus.key_reject, bus.digit_count, bus.digits);
    end
    key(4'hC);
    n_vec++;
    if (bus.negative !== 1'b1 || bus.key_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL p2_sign actual neg=%b rej=%b required 1/0", bus.negative, bus.key_reject);
    end
    key(4'hD);
    idle(MD + 1);
    n_vec++;
    if (bus.result !== 16'hD8F1 || bus.overflow !== 1'b0 || bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL p2_result actual res=%h ovf=%b v=%b required d8f1/0/1",
               bus.result, bus.overflow, bus.result_valid);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backspace();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    key(4'd4); key(4'd5); key(4'hA); key(4'd7);
    n_vec++;
    if (bus.digits !== 16'h0047 || bus.digit_count !== 3'd2) begin
      n_bad++;
      $display("FAIL p3_edit actual digits=%h cnt=%0d required 0047/2", bus.digits, bus.digit_count);
    end
    key(4'hA); key(4'hA);
    n_vec++;
    if (bus.digit_count !== 3'd0 || bus.digits !== 16'h0 || bus.key_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL p3_empty actual cnt=%0d digits=%h rej=%b required 0/0000/0",
               bus.digit_count, bus.digits, bus.key_reject);
    end
    key(4'hA);
    n_vec++;
    if (bus.key_reject !== 1'b1) begin
      n_bad++;
      $display("FAIL p3_reject actual rej=%b required 1", bus.key_reject);
    end
    idle(1);
    n_vec++;
    if (bus.key_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL p3_pulse actual rej=%b required 0", bus.key_reject);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    key(4'd2); key(4'd0); key(4'd0); key(4'hD);
    idle(MD + 1);
    n_vec++;
    if (bus8.result !== 8'd127 || bus8.overflow !== 1'b1 || bus.result !== 16'd200 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL p4_pos actual r8=%0d o8=%b r16=%0d o16=%b required 127/1/200/0",
               $signed(bus8.result), bus8.overflow, $signed(bus.result), bus.overflow);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0);
    n_vec++;
    if (bus8.overflow !== 1'b0 || bus8.result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL p4_ack actual ovf=%b v=%b required 0/0", bus8.overflow, bus8.result_valid);
    end
    key(4'd1); key(4'd2); key(4'd8); key(4'hC); key(4'hD);
    idle(MD + 1);
    n_vec++;
    if (bus8.result !== 8'h80 || bus8.overflow !== 1'b0 || bus.result !== 16'hFF80) begin
      n_bad++;
      $display("FAIL p4_neg actual r8=%h o8=%b r16=%h required 80/0/ff80",
               bus8.result, bus8.overflow, bus.result);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0);
    key(4'd1); key(4'd2); key(4'd9); key(4'hC); key(4'hD);
    idle(MD + 1);
    n_vec++;
    if (bus8.result !== 8'h80 || bus8.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL p4_negsat actual r8=%h o8=%b required 80/1", bus8.result, bus8.overflow);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_and_collision();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    key(4'd0);
    n_vec++;
    if (bus.key_reject !== 1'b0 || bus.digit_count !== 3'd0) begin
      n_bad++;
      $display("FAIL p5_zero actual rej=%b cnt=%0d required 0/0", bus.key_reject, bus.digit_count);
    end
    key(4'hD);
    idle(MD + 1);
    n_vec++;
    if (bus.result !== 16'd0 || bus.result_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL p5_result actual res=%h v=%b ovf=%b required 0/1/0",
               bus.result, bus.result_valid, bus.overflow);
    end
    step(1'b1, 4'd5, 1'b1, 1'b0);
    n_vec++;
    if (bus.result_valid !== 1'b0 || bus.key_reject !== 1'b1 || bus.digit_count !== 3'd0) begin
      n_bad++;
      $display("FAIL p5_collide actual v=%b rej=%b cnt=%0d required 0/1/0",
               bus.result_valid, bus.key_reject, bus.digit_count);
    end
    key(4'd3);
    n_vec++;
    if (bus.digit_count !== 3'd1 || bus.digits !== 16'h0003 || bus.key_reject !== 1'b0) begin
      n_bad++;
      $display("FAIL p5_nextkey actual cnt=%0d digits=%h rej=%b required 1/0003/0",
               bus.digit_count, bus.digits, bus.key_reject);
    end
  endtask

  task automatic test_reset_mid_convert();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    key(4'd8); key(4'hC); key(4'hD);
    idle(1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    n_vec++;
    if ({bus.digits, bus.digit_count, bus.negative, bus.busy, bus.result,
         bus.result_valid, bus.overflow, bus.key_reject} !== '0) begin
      n_bad++;
      $display("FAIL p6_reset actual digits=%h cnt=%0d neg=%b busy=%b res=%h v=%b required all 0",
               bus.digits, bus.digit_count, bus.negative, bus.busy, bus.result, bus.result_valid);
    end
    for (int i = 0; i < MD + 2; i++) begin
      idle(1);
      n_vec++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL p6_novalid cycle %0d actual v=%b busy=%b required 0/0", i, bus.result_valid, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit kv, ack, rst;
    logic [3:0] kc;
    int r;
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      kv  = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 19);
      case (r)
        10, 11:  kc = 4'hA;
        12:      kc = 4'hB;
        13, 14:  kc = 4'hC;
        15, 16:  kc = 4'hD;
        17:      kc = 4'hE;
        18:      kc = 4'hF;
        19:      kc = 4'h0;
        default: kc = 4'(r);
      endcase
      ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(kv, kc, ack, rst);
      n_vec++;
      if ({bus.digits, bus.digit_count, bus.negative, bus.busy, bus.result_valid, bus.key_reject} !==
          {m_bcd(), 3'(mq.size()), m_neg, m_state == M_CONV, m_state == M_HOLD, m_rej}) begin
        n_bad++;
        $display("FAIL rnd_ctrl cyc %0d actual digits=%h cnt=%0d neg=%b busy=%b v=%b rej=%b required %h/%0d/%b/%b/%b/%b",
                 n, bus.digits, bus.digit_count, bus.negative, bus.busy, bus.result_valid, bus.key_reject,
                 m_bcd(), mq.size(), m_neg, m_state == M_CONV, m_state == M_HOLD, m_rej);
      end
      n_vec++;
      if (bus.result !== 16'(m_res16) || bus.overflow !== m_ovf16) begin
        n_bad++;
        $display("FAIL rnd_res16 cyc %0d actual res=%0d ovf=%b required %0d/%b",
                 n, $signed(bus.result), bus.overflow, m_res16, m_ovf16);
      end
      n_vec++;
      if (bus8.result !== 8'(m_res8) || bus8.overflow !== m_ovf8 || bus8.digits !== m_bcd()) begin
        n_bad++;
        $display("FAIL rnd_res8 cyc %0d actual res=%0d ovf=%b digits=%h required %0d/%b/%h",
                 n, $signed(bus8.result), bus8.overflow, bus8.digits, m_res8, m_ovf8, m_bcd());
      end
    end
  endtask

  initial begin
    bus.key_valid = 1'b0;  bus.key_code = 4'h0;  bus.result_ack = 1'b0;
    bus8.key_valid = 1'b0; bus8.key_code = 4'h0; bus8.result_ack = 1'b0;
    test_reset();
    test_entry_convert();
    test_digit_limit_sign();
    test_backspace();
    test_saturation();
    test_zero_and_collision();
    test_reset_mid_convert();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_number_entry.md
# keypad_number_entry

Parametrised keypad number-entry controller for the calculator datapath. It accepts one-cycle key events and builds a signed decimal operand of up to MAX_DIGITS digits, with backspace, clear and sign toggle. On enter it converts the BCD digits to two's-complement binary over a fixed number of cycles. It then holds the result under a valid/ack handshake for the ALU front end, while the BCD digits drive the display.

## Interface
- MAX_DIGITS, 4: maximum stored decimal digits (≥1).
- WIDTH, 16: result width in bits, signed two's complement (≥2).
- ALLOW_NEGATIVE, 1: when 0, the sign key is rejected and the result is always non-negative.
- CW: derived local, $clog2(MAX_DIGITS+1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; returns the block to EMPTY.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  4  0–9 digit; 0xA backspace; 0xB clear; 0xC sign toggle; 0xD enter; 0xE/0xF invalid.
- result_ack  in  1  consumer accepts the result.
- digits  out  4*MAX_DIGITS  BCD digits, nibble 0 least significant.
- digit_count  out  CW  number of stored digits.
- negative  out  1  current sign flag.
- busy  out  1  high in CONVERT.
- result  out  WIDTH  signed converted value.
- result_valid  out  1  high in HOLD.
- overflow  out  1  the magnitude did not fit; result is saturated. Valid with result_valid.
- key_reject  out  1  one-cycle pulse, one cycle after an ignored key event.

## Operation
States are EMPTY, ENTRY, CONVERT and HOLD. All key actions apply only when key_valid=1.

- **EMPTY** (digit_count=0)
  - Digit 1–9: shift it into nibble 0, count=1, go to ENTRY.
  - Digit 0: leading zero, ignored; no reject.
  - Sign: toggles negative (reject if ALLOW_NEGATIVE=0).
  - Enter: go to CONVERT.
  - Clear: clears negative.
  - Backspace or invalid code: reject.
- **ENTRY**
  - Digit with count<MAX_DIGITS: digits shift left one nibble, new digit into nibble 0, count+1.
  - Digit with count==MAX_DIGITS: reject; no change.
  - Backspace: digits shift right one nibble, top nibble=0, count−1. If count reaches 0, go to EMPTY; negative is retained.
  - Clear: digits=0, count=0, negative=0, go to EMPTY.
  - Sign: as in EMPTY.
  - Enter: go to CONVERT.
  - Invalid code: reject.
- **CONVERT**
  - Takes exactly MAX_DIGITS cycles. Each cycle: acc = acc*10 + digit[i], for i = MAX_DIGITS−1 down to 0.
  - acc is wide enough to hold 10^MAX_DIGITS−1 without loss; it is cleared on entry to CONVERT.
  - Every key is rejected.
  - On the last cycle:
    - Positive limit: if negative=0 and acc > 2^(WIDTH−1)−1, result=2^(WIDTH−1)−1 and overflow=1.
    - Negative limit: if negative=1 and acc > 2^(WIDTH−1), result=−2^(WIDTH−1) and overflow=1.
    - Otherwise result = negative ? −acc : acc and overflow=0.
    - A magnitude of 0 gives result 0 regardless of sign.
  - Go to HOLD.
- **HOLD**
  - result, overflow, digits and negative are stable.
  - result_ack: digits=0, count=0, negative=0, overflow=0, go to EMPTY.
  - Keys are rejected. If result_ack and key_valid are asserted in the same cycle, the ack is taken and the key is rejected.
- result_ack outside HOLD: ignored.
- reset in any state, including mid-CONVERT: all state cleared on the next edge.

## Timing
- All outputs are registered.
- Reset values:
  - state EMPTY.
  - digits, digit_count, negative, busy, result, result_valid, overflow, key_reject all 0.
- Key event at edge t: digits, digit_count and negative update at t+1; key_reject pulses during t+1.
- Enter at edge t: busy=1 from t+1 through t+MAX_DIGITS; result_valid=1 from t+MAX_DIGITS+1.
- Enter-to-valid latency is MAX_DIGITS+1 cycles and independent of digit_count.
- result_ack sampled at edge u while valid: result_valid=0 and state is EMPTY at u+1. The first new key is accepted at edge u+1.
- Back-to-back key events on consecutive cycles are each processed. No key event is ever queued.

## Test plan
All scenarios use MAX_DIGITS=4, WIDTH=16 unless stated.

1. Keys 1,2,3 then enter at edge t. Required: digits=0x0123 and count=3 before enter; busy high during t+1..t+4; result=123, result_valid=1 at t+5; ack leads to EMPTY with digits=0.
2. Keys 9×5, then sign, then enter. Required: the 5th digit gives a key_reject pulse and count stays 4; result=−9999 (0xD8F1) with overflow=0.
3. Keys 4,5, backspace, 7. Required: digits=0x0047, count=2. Then backspace ×2: EMPTY, count=0. A third backspace: key_reject pulse.
4. WIDTH=8: keys 2,0,0, enter gives result=127, overflow=1. Keys 1,2,8, sign, enter gives result=−128, overflow=0.
5. Key 0 in EMPTY: no reject, count stays 0. Enter then gives result=0. In HOLD, assert result_ack and a digit key in the same cycle: required state EMPTY, key_reject=1, count=0.
6. Reset asserted mid-CONVERT (2nd cycle): required all outputs 0 and EMPTY next cycle, with no result_valid pulse.
